// File: rtl/lza_detect_tree_pipe_pkg.sv
// Shared types and elaboration helpers for the LZA shift-correction detector.
package lza_detect_tree_pipe_pkg;

  // Class of the first / second non-z digit in a segment.
  typedef enum logic [1:0] {
    DigNone = 2'd0,
    DigN    = 2'd1,
    DigP    = 2'd2
  } dig_e;

  // Segment summary: all digits z, first non-z digit, second non-z digit.
  typedef struct packed {
    logic allz;
    dig_e f;
    dig_e s;
  } summ_t;

  // Tree levels completed before stage k; earlier stages absorb the remainder.
  function automatic int unsigned lvls_before(input int unsigned k, input int unsigned lv,
                                              input int unsigned s);
    int unsigned extra;
    extra = lv % s;
    return k * (lv / s) + ((k < extra) ? k : extra);
  endfunction

  // Stage whose register sits after tree level l, or -1 if level l is not a stage boundary.
  function automatic int stage_of_end(input int unsigned l, input int unsigned lv,
                                      input int unsigned s);
    for (int unsigned k = 0; k < s; k++) begin
      if (lvls_before(k + 1, lv, s) == l) return int'(k);
    end
    return -1;
  endfunction

  // Single-digit summary; a z digit (or a pad) is allz.
  function automatic summ_t leaf(input logic n, input logic p);
    summ_t r;
    r.allz = ~(n | p);
    r.f    = n ? DigN : (p ? DigP : DigNone);
    r.s    = DigNone;
    return r;
  endfunction

endpackage

// File: rtl/dt_seg_merge.sv
// Combinational merge of an MSB-half and an LSB-half segment summary.
module dt_seg_merge
  import lza_detect_tree_pipe_pkg::*;
(
  input  summ_t hi_i,
  input  summ_t lo_i,
  output summ_t merged_o
);

  // Upper half decides unless it is all z or still lacks its second digit.
  always_comb begin
    merged_o = hi_i;
    if (hi_i.allz) begin
      merged_o = lo_i;
    end else if (hi_i.s == DigNone) begin
      merged_o.s = lo_i.allz ? DigNone : lo_i.f;
    end
  end

endmodule

// File: rtl/lza_detect_tree_pipe.sv
// Pipelined LZA shift-correction detector: leaf encode, summary tree split over
// PIPE_STAGES registered stages with a valid/ready chain, final pos/neg decode.
module lza_detect_tree_pipe
  import lza_detect_tree_pipe_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned PIPE_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            mode,
  input  logic [DATA_WIDTH-1:0] string_n_pos,
  input  logic [DATA_WIDTH-1:0] string_z_pos,
  input  logic [DATA_WIDTH-1:0] string_p_pos,
  input  logic [DATA_WIDTH-1:0] string_n_neg,
  input  logic [DATA_WIDTH-1:0] string_z_neg,
  input  logic [DATA_WIDTH-1:0] string_p_neg,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  corr_pos,
  output logic                  corr_neg,
  output logic                  nshift_correct,
  output logic                  onehot_err
);

  localparam int unsigned Levels = $clog2(DATA_WIDTH);
  localparam int unsigned PadW   = 1 << Levels;
  localparam int unsigned Stages = PIPE_STAGES;
  localparam int unsigned TotN   = 2 * PadW - 1;
  localparam int unsigned RootIx = TotN - 1;

  // ---------------- handshake chain ----------------
  logic [Stages-1:0] valid_q;
  logic [Stages:0]   rdy;
  logic [Stages-1:0] vin;
  logic [Stages-1:0] ld;

  // Ready ripples back from the output; a stage loads when its input is valid and it is ready.
  always_comb begin
    rdy[Stages] = out_ready;
    for (int k = int'(Stages) - 1; k >= 0; k--) rdy[k] = ~valid_q[k] | rdy[k+1];
    vin[0] = in_valid;
    for (int k = 1; k < int'(Stages); k++) vin[k] = valid_q[k-1];
    ld = rdy[Stages-1:0] & vin;
  end

  // ---------------- stage 0: one-hot check and padded digits ----------------
  logic [DATA_WIDTH-1:0] one_pos, one_neg;
  logic                  err_c;
  logic [PadW-1:0]       n_pad [2];
  logic [PadW-1:0]       p_pad [2];

  assign one_pos = (string_n_pos ^ string_z_pos ^ string_p_pos) &
                   ~(string_n_pos & string_z_pos & string_p_pos);
  assign one_neg = (string_n_neg ^ string_z_neg ^ string_p_neg) &
                   ~(string_n_neg & string_z_neg & string_p_neg);
  assign err_c   = ~(&one_pos) | ~(&one_neg);

  // Pads occupy the LSB end and read as z (neither n nor p).
  assign n_pad[0] = PadW'(string_n_pos) << (PadW - DATA_WIDTH);
  assign p_pad[0] = PadW'(string_p_pos) << (PadW - DATA_WIDTH);
  assign n_pad[1] = PadW'(string_n_neg) << (PadW - DATA_WIDTH);
  assign p_pad[1] = PadW'(string_p_neg) << (PadW - DATA_WIDTH);

  // ---------------- error / mode side pipeline ----------------
  logic [Stages-1:0] err_q, err_in;
  logic [1:0]        mode_q  [Stages];
  logic [1:0]        mode_in [Stages];

  // Side-band fields enter with the beat and follow it stage by stage.
  always_comb begin
    err_in[0]  = err_c;
    mode_in[0] = mode;
    for (int k = 1; k < int'(Stages); k++) begin
      err_in[k]  = err_q[k-1];
      mode_in[k] = mode_q[k-1];
    end
  end

  // Valid bits move on ready; side-band data only on load so bubbles do not toggle it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      err_q   <= '0;
      for (int k = 0; k < int'(Stages); k++) mode_q[k] <= '0;
    end else begin
      for (int k = 0; k < int'(Stages); k++) begin
        if (rdy[k]) valid_q[k] <= vin[k];
        if (ld[k]) begin
          err_q[k]  <= err_in[k];
          mode_q[k] <= mode_in[k];
        end
      end
    end
  end

  // ---------------- summary trees (index 0 = pos, 1 = neg) ----------------
  // Flat node storage per path: level l occupies [Base, Base + (PadW >> l)).
  summ_t node_c [2][TotN];
  summ_t node   [2][TotN];

  for (genvar l = 0; l <= int'(Levels); l++) begin : g_lvl
    localparam int unsigned Nodes    = PadW >> l;
    localparam int unsigned Base     = 2 * PadW - 2 * (PadW >> l);
    localparam int unsigned PrevBase = (l == 0) ? 0 : 2 * PadW - 2 * (PadW >> (l - 1));
    localparam int          EndStage = stage_of_end(l, Levels, Stages);
    for (genvar pth = 0; pth < 2; pth++) begin : g_path
      for (genvar j = 0; j < int'(Nodes); j++) begin : g_node
        if (l == 0) begin : g_leaf
          assign node_c[pth][Base+j] = leaf(n_pad[pth][j], p_pad[pth][j]);
        end else begin : g_merge
          dt_seg_merge u_merge (
            .hi_i    (node[pth][PrevBase+2*j+1]),
            .lo_i    (node[pth][PrevBase+2*j]),
            .merged_o(node_c[pth][Base+j])
          );
        end
      end
      if (EndStage >= 0) begin : g_reg
        summ_t q [Nodes];
        // Stage boundary: capture this level's summaries when the stage loads.
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            for (int unsigned j = 0; j < Nodes; j++) q[j] <= '0;
          end else if (ld[EndStage]) begin
            for (int unsigned j = 0; j < Nodes; j++) q[j] <= node_c[pth][Base+j];
          end
        end
        for (genvar j = 0; j < int'(Nodes); j++) begin : g_out
          assign node[pth][Base+j] = q[j];
        end
      end else begin : g_thru
        for (genvar j = 0; j < int'(Nodes); j++) begin : g_out
          assign node[pth][Base+j] = node_c[pth][Base+j];
        end
      end
    end
  end

  // ---------------- final decode ----------------
  summ_t root_pos, root_neg;
  logic  y_pos, n_pos, y_neg, p_neg;

  assign root_pos = node[0][RootIx];
  assign root_neg = node[1][RootIx];

  // Pos needs p then n; neg needs n then p; a bad digit anywhere suppresses both.
  always_comb begin
    y_pos    = (root_pos.f == DigP) && (root_pos.s == DigN);
    n_pos    = (root_pos.f == DigN);
    y_neg    = (root_neg.f == DigN) && (root_neg.s == DigP);
    p_neg    = (root_neg.f == DigP);
    corr_pos = mode_q[Stages-1][0] & y_pos & ~n_pos & ~err_q[Stages-1];
    corr_neg = mode_q[Stages-1][1] & y_neg & ~p_neg & ~err_q[Stages-1];
  end

  assign nshift_correct = corr_pos | corr_neg;
  assign onehot_err     = err_q[Stages-1];
  assign out_valid      = valid_q[Stages-1];
  assign in_ready       = rdy[0];

endmodule

// File: tb/tb_lza_detect_tree_pipe.sv
// Directed self-checking bench: W=8/2-stage instance plus a W=6/1-stage padded instance.
module tb_lza_detect_tree_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // W=8, PIPE_STAGES=2
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [1:0] mode;
  logic [7:0] pn, pz, pp, nn, nz, np;
  logic       corr_pos, corr_neg, nshift, oerr;
  logic [4:0] o8;

  // W=6, PIPE_STAGES=1
  logic       in_valid6, in_ready6, out_valid6, out_ready6;
  logic [1:0] mode6;
  logic [5:0] pn6, pz6, pp6, nn6, nz6, np6;
  logic       corr_pos6, corr_neg6, nshift6, oerr6;
  logic [4:0] o6;

  assign o8 = {out_valid, corr_pos, corr_neg, nshift, oerr};
  assign o6 = {out_valid6, corr_pos6, corr_neg6, nshift6, oerr6};

  lza_detect_tree_pipe #(.DATA_WIDTH(8), .PIPE_STAGES(2)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
    .string_n_pos(pn), .string_z_pos(pz), .string_p_pos(pp),
    .string_n_neg(nn), .string_z_neg(nz), .string_p_neg(np),
    .out_valid(out_valid), .out_ready(out_ready), .corr_pos(corr_pos), .corr_neg(corr_neg),
    .nshift_correct(nshift), .onehot_err(oerr)
  );

  lza_detect_tree_pipe #(.DATA_WIDTH(6), .PIPE_STAGES(1)) u_dut6 (
    .clk(clk), .rst(rst), .in_valid(in_valid6), .in_ready(in_ready6), .mode(mode6),
    .string_n_pos(pn6), .string_z_pos(pz6), .string_p_pos(pp6),
    .string_n_neg(nn6), .string_z_neg(nz6), .string_p_neg(np6),
    .out_valid(out_valid6), .out_ready(out_ready6), .corr_pos(corr_pos6), .corr_neg(corr_neg6),
    .nshift_correct(nshift6), .onehot_err(oerr6)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 2 time units after the edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drv8(input logic v, input logic [1:0] md,
                      input logic [7:0] a_n, input logic [7:0] a_z, input logic [7:0] a_p,
                      input logic [7:0] b_n, input logic [7:0] b_z, input logic [7:0] b_p);
    in_valid = v; mode = md;
    pn = a_n; pz = a_z; pp = a_p; nn = b_n; nz = b_z; np = b_p;
  endtask

  task automatic drv6(input logic v, input logic [1:0] md,
                      input logic [5:0] a_n, input logic [5:0] a_z, input logic [5:0] a_p,
                      input logic [5:0] b_n, input logic [5:0] b_z, input logic [5:0] b_p);
    in_valid6 = v; mode6 = md;
    pn6 = a_n; pz6 = a_z; pp6 = a_p; nn6 = b_n; nz6 = b_z; np6 = b_p;
  endtask

  initial begin
    rst = 1'b1;
    out_ready = 1'b1; out_ready6 = 1'b1;
    drv8(1'b0, 2'b00, 8'h00, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'h00);
    drv6(1'b0, 2'b00, 6'h00, 6'h3F, 6'h00, 6'h00, 6'h3F, 6'h00);
    #1;
    check("rst_outputs", {3'b0, o8}, 8'h00);
    check("rst_outputs6", {3'b0, o6}, 8'h00);
    tick(); tick();
    rst = 1'b0;
    tick();
    check("ready_after_rst", {7'b0, in_ready}, 8'h01);
    check("idle_outputs", {3'b0, o8}, 8'h00);

    // 1: zzpznzzz on pos -> correction two cycles later
    drv8(1'b1, 2'b11, 8'h08, 8'hD7, 8'h20, 8'h00, 8'hFF, 8'h00);
    tick();
    in_valid = 1'b0;
    check("t1_not_yet", {3'b0, o8}, 8'h00);
    tick();
    check("t1_corr_pos", {3'b0, o8}, 8'b000_11010);

    // 2: zzpzpzzz (no corr) then neg nzzzpzzz (corr_neg), back to back
    drv8(1'b1, 2'b11, 8'h00, 8'hD7, 8'h28, 8'h00, 8'hFF, 8'h00);
    tick();
    drv8(1'b1, 2'b11, 8'h00, 8'hFF, 8'h00, 8'h80, 8'h77, 8'h08);
    tick();
    check("t2_beat_a", {3'b0, o8}, 8'b000_10000);
    in_valid = 1'b0;
    tick();
    check("t2_beat_b", {3'b0, o8}, 8'b000_10110);
    tick();
    check("t2_drain", {7'b0, out_valid}, 8'h00);

    // 3: stall with four offered beats; only two fit, then in-order drain
    out_ready = 1'b0;
    drv8(1'b1, 2'b11, 8'h08, 8'hD7, 8'h20, 8'h00, 8'hFF, 8'h00);
    check("t3_rdy0", {7'b0, in_ready}, 8'h01);
    tick();
    drv8(1'b1, 2'b11, 8'h00, 8'hD7, 8'h28, 8'h00, 8'hFF, 8'h00);
    check("t3_rdy1", {7'b0, in_ready}, 8'h01);
    tick();
    drv8(1'b1, 2'b11, 8'h00, 8'hFF, 8'h00, 8'h80, 8'h77, 8'h08);
    check("t3_full", {7'b0, in_ready}, 8'h00);
    check("t3_head_b0", {3'b0, o8}, 8'b000_11010);
    tick();
    check("t3_still_full", {7'b0, in_ready}, 8'h00);
    check("t3_hold_b0", {3'b0, o8}, 8'b000_11010);
    out_ready = 1'b1;
    #1;
    check("t3_rdy_release", {7'b0, in_ready}, 8'h01);
    tick();
    check("t3_out_b1", {3'b0, o8}, 8'b000_10000);
    drv8(1'b1, 2'b11, 8'h08, 8'hD7, 8'h20, 8'h00, 8'hFF, 8'h00);
    tick();
    check("t3_out_b2", {3'b0, o8}, 8'b000_10110);
    in_valid = 1'b0;
    tick();
    check("t3_out_b3", {3'b0, o8}, 8'b000_11010);
    tick();
    check("t3_empty", {7'b0, out_valid}, 8'h00);

    // 4: digit 3 both n and p -> error, then a clean beat clears it
    drv8(1'b1, 2'b11, 8'h08, 8'hD7, 8'h28, 8'h00, 8'hFF, 8'h00);
    tick();
    drv8(1'b1, 2'b11, 8'h08, 8'hD7, 8'h20, 8'h00, 8'hFF, 8'h00);
    tick();
    check("t4_onehot_err", {3'b0, o8}, 8'b000_10001);
    in_valid = 1'b0;
    tick();
    check("t4_err_clear", {3'b0, o8}, 8'b000_11010);

    // 5: mode masking of the pos path
    drv8(1'b1, 2'b10, 8'h08, 8'hD7, 8'h20, 8'h00, 8'hFF, 8'h00);
    tick();
    drv8(1'b1, 2'b01, 8'h08, 8'hD7, 8'h20, 8'h00, 8'hFF, 8'h00);
    tick();
    check("t5_mode10", {3'b0, o8}, 8'b000_10000);
    in_valid = 1'b0;
    tick();
    check("t5_mode01", {3'b0, o8}, 8'b000_11010);

    // 6: reset with two beats in flight
    out_ready = 1'b0;
    drv8(1'b1, 2'b11, 8'h08, 8'hD7, 8'h20, 8'h00, 8'hFF, 8'h00);
    tick();
    tick();
    in_valid = 1'b0;
    check("t6_full", {3'b0, o8}, 8'b000_11010);
    rst = 1'b1;
    #1;
    check("t6_async_clear", {3'b0, o8}, 8'h00);
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    tick();
    check("t6_ready", {7'b0, in_ready}, 8'h01);
    check("t6_discard", {3'b0, o8}, 8'h00);
    tick();
    check("t6_discard2", {7'b0, out_valid}, 8'h00);

    // W=6, one stage: padding at LSB end, latency of one edge
    drv6(1'b1, 2'b11, 6'h04, 6'h2B, 6'h10, 6'h00, 6'h3F, 6'h00);
    tick();
    check("w6_corr_pos", {3'b0, o6}, 8'b000_11010);
    drv6(1'b1, 2'b11, 6'h00, 6'h3E, 6'h01, 6'h00, 6'h3F, 6'h00);
    tick();
    check("w6_pad_none", {3'b0, o6}, 8'b000_10000);
    drv6(1'b1, 2'b11, 6'h01, 6'h3C, 6'h02, 6'h00, 6'h3F, 6'h00);
    tick();
    check("w6_lsb_pair", {3'b0, o6}, 8'b000_11010);
    drv6(1'b1, 2'b11, 6'h00, 6'h3F, 6'h00, 6'h20, 6'h0F, 6'h10);
    tick();
    check("w6_corr_neg", {3'b0, o6}, 8'b000_10110);
    in_valid6 = 1'b0;
    tick();
    check("w6_drain", {7'b0, out_valid6}, 8'h00);

    out_ready6 = 1'b0;
    drv6(1'b1, 2'b11, 6'h04, 6'h2B, 6'h10, 6'h00, 6'h3F, 6'h00);
    tick();
    in_valid6 = 1'b0;
    check("w6_held", {3'b0, o6}, 8'b000_11010);
    check("w6_full", {7'b0, in_ready6}, 8'h00);
    rst = 1'b1;
    #1;
    check("w6_async_clear", {3'b0, o6}, 8'h00);
    tick();
    rst = 1'b0;
    out_ready6 = 1'b1;
    tick();
    check("w6_ready", {7'b0, in_ready6}, 8'h01);
    check("w6_discard", {3'b0, o6}, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
